stream_source: RTL
==================

STREAM_SOURCE -- requirements
Module: stream_source

Interface
REQ-001 The module SHALL take these parameters (name, default, meaning):
- WIDTH, -1: active image width in pixels.
- HEIGHT, -1: active image height in lines.
- W_WIDTH, -1: frame width including blanking; must be ≥ WIDTH.
- W_HEIGHT, -1: frame height including blanking; must be ≥ HEIGHT.
- BIT_WIDTH, -1: pixel bit width.
- FIFO_DEPTH, 16: input FIFO entries; must be a power of 2 and ≥ 2.
- PRIME_LEVEL, 16: FIFO occupancy required to begin the frame; must satisfy 1 ≤ PRIME_LEVEL ≤ FIFO_DEPTH.

REQ-002 The module SHALL have these ports (name, direction, width, meaning); H_BITW=ceil(log2(W_WIDTH)) and V_BITW=ceil(log2(W_HEIGHT)):
- clock, in, 1: the single clock.
- n_rst, in, 1: asynchronous active-low reset.
- start, in, 1: frame request; sampled only in IDLE.
- in_valid, in, 1: host pixel valid.
- in_pixel, in, BIT_WIDTH: host pixel data.
- in_ready, out, 1: FIFO can accept a pixel.
- out_enable, out, 1: stream enable for the downstream layer.
- out_pixel, out, BIT_WIDTH: stream pixel.
- out_vcnt, out, V_BITW: frame line coordinate.
- out_hcnt, out, H_BITW: frame column coordinate.
- busy, out, 1: high in PRIME and RUN.
- done, out, 1: one-cycle pulse at frame end.
- underrun, out, 1: sticky FIFO-empty-in-active-region flag.

Function
REQ-003 The FSM SHALL have three states, IDLE, PRIME and RUN, and SHALL reset to IDLE.
REQ-004 In IDLE with start=1, the FSM SHALL go to PRIME next cycle and clear underrun; start SHALL be ignored in PRIME and RUN.
REQ-005 In PRIME, the FSM SHALL go to RUN on the cycle after FIFO occupancy ≥ PRIME_LEVEL; occupancy is evaluated after that cycle's push.
REQ-006 Handshake: in_ready SHALL be high when state≠IDLE and occupancy<FIFO_DEPTH; a push SHALL occur only on in_valid&&in_ready; in IDLE in_ready=0 and in_valid SHALL be ignored.
REQ-007 In RUN, an internal (v,h) counter SHALL advance once per clock:
- h: 0..W_WIDTH-1, wrapping to 0.
- v: increments on h wrap, range 0..W_HEIGHT-1.
REQ-008 Active position: h<WIDTH && v<HEIGHT.
- Active and FIFO non-empty: pop one entry.
- Active and FIFO empty: no pop, and set underrun.
REQ-009 Outputs SHALL be registered and mutually aligned, taking effect one cycle after the position is processed:
- out_enable=1.
- out_hcnt=h, out_vcnt=v.
- out_pixel = popped data when active and popped; otherwise 0.
REQ-010 At position (W_HEIGHT-1, W_WIDTH-1), the FSM SHALL return to IDLE and reset the counter to (0,0).
REQ-011 done SHALL pulse in the same cycle that the last position's outputs appear; out_enable SHALL be 0 on the following cycle.
REQ-012 In IDLE and PRIME, outputs SHALL be: out_enable=0, out_pixel=0, out_hcnt=0, out_vcnt=0.
REQ-013 A simultaneous push and pop SHALL leave occupancy unchanged; the FIFO SHALL never overflow, and pop SHALL never occur when empty.
REQ-014 FIFO contents SHALL persist across IDLE: surplus pixels remain and count toward the next frame's PRIME.
REQ-015 Frame length SHALL be exactly W_WIDTH*W_HEIGHT cycles of out_enable=1.

Reset
REQ-016 On n_rst=0, asynchronously and regardless of state (including mid-frame):
- FSM = IDLE, counter = (0,0), FIFO emptied.
- All outputs 0: in_ready, out_enable, out_pixel, out_vcnt, out_hcnt, busy, done, underrun.
REQ-017 After n_rst deasserts, the first start SHALL be accepted on the first rising edge.

Verification
Bench parameters: WIDTH=4, HEIGHT=2, W_WIDTH=6, W_HEIGHT=3, BIT_WIDTH=8, FIFO_DEPTH=8, PRIME_LEVEL=4.
REQ-018 Nominal frame: push pixels 1..8 continuously, pulse start.
- 18 cycles of out_enable=1.
- (0,0..3) carry 1..4 and (1,0..3) carry 5..8; all blanking positions carry 0.
- done pulses with (2,5); underrun=0.
REQ-019 Underrun: push only 5 pixels, then hold in_valid=0.
- Position (1,1) onward outputs 0 at active positions; underrun=1 and stays high until the next start.
REQ-020 Backpressure: in_valid held high with 12 pixels.
- in_ready drops when occupancy reaches 8; no pixel is lost or duplicated; output order matches push order.
REQ-021 Mid-frame reset: assert n_rst=0 at (1,2).
- All outputs 0 immediately; FIFO empty.
- A subsequent start plus 8 pushes produces a clean frame starting at (0,0).
REQ-022 Start ignored: pulse start during RUN and PRIME.
- No restart, counter unaffected; back-to-back frames with surplus FIFO data enter RUN without waiting for new pushes.

Source files
------------

// File: rtl/stream_source.sv
// Stream source: buffers host pixels in a small FIFO, then emits one frame
// Ports: clock/n_rst, start, in_valid/in_pixel/in_ready, out_*, busy, done, underrun
module stream_source #(
  parameter int WIDTH       = -1,
  parameter int HEIGHT      = -1,
  parameter int W_WIDTH     = -1,
  parameter int W_HEIGHT    = -1,
  parameter int BIT_WIDTH   = -1,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 16,
  localparam int PW     = (BIT_WIDTH > 0) ? BIT_WIDTH : 1,
  localparam int H_BITW = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1,
  localparam int V_BITW = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PW-1:0]     in_pixel,
  output logic              in_ready,
  output logic              out_enable,
  output logic [PW-1:0]     out_pixel,
  output logic [V_BITW-1:0] out_vcnt,
  output logic [H_BITW-1:0] out_hcnt,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);
  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_ONE  = 1;
  localparam logic [V_BITW-1:0] V_ONE  = 1;
  localparam logic [AW:0]       P_ONE  = 1;

  logic [1:0]        state;
  logic [H_BITW-1:0] h;
  logic [V_BITW-1:0] v;

  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;
  logic empty;
  logic active;
  logic last;
  logic prime_hit;

  // Pointers carry one extra bit so a full FIFO is count == DEPTH.
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign in_ready = busy && !count[AW];
  assign push     = in_valid && in_ready;

  assign active = (state == RUN)
               && (int'(h) < WIDTH)
               && (int'(v) < HEIGHT);
  assign pop    = active && !empty;
  assign last   = (h == H_LAST) && (v == V_LAST);

  // Priming looks at occupancy including this cycle's push.
  assign prime_hit =
    (int'(count) + int'(push)) >= PRIME_LEVEL;

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= in_pixel;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + P_ONE;
      if (pop)
        rd_ptr <= rd_ptr + P_ONE;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      h          <= '0;
      v          <= '0;
      out_enable <= 1'b0;
      out_pixel  <= '0;
      out_hcnt   <= '0;
      out_vcnt   <= '0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      out_enable <= 1'b0;
      out_pixel  <= '0;
      out_hcnt   <= '0;
      out_vcnt   <= '0;
      done       <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            state    <= PRIME;
            underrun <= 1'b0;
          end
        end
        (state == PRIME): begin
          if (prime_hit)
            state <= RUN;
        end
        (state == RUN): begin
          out_enable <= 1'b1;
          out_hcnt   <= h;
          out_vcnt   <= v;
          if (pop)
            out_pixel <= mem[rd_ptr[AW-1:0]];
          if (active && empty)
            underrun <= 1'b1;
          if (last) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
            done  <= 1'b1;
          end else if (h == H_LAST) begin
            h <= '0;
            v <= v + V_ONE;
          end else begin
            h <= h + H_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
